cmd_issuer: RTL and testbench



---
 rtl/cmd_issuer.sv | 157 +++++++++++++++
 tb/tb_cmd_issuer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_issuer.sv
// Command issuer: pops commands from the queue FIFO, drops NOPs, drains on BARRIER and
// dispatches everything else round-robin to N_PE processing elements. Optional: ISSUER_PERF_CNT_EN.
module cmd_issuer #(
   parameter int CMD_WIDTH = 248,
   parameter int N_PE      = 4,
   parameter int PE_IDX_W  = $clog2(N_PE)
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic                 i_fifo_empty,
   input  logic [CMD_WIDTH-1:0] i_cmd,
   output logic                 o_read,
   output logic [CMD_WIDTH-1:0] o_cmd,
   output logic [N_PE-1:0]      o_pe_valid,
   input  logic [N_PE-1:0]      i_pe_ready,
   input  logic [N_PE-1:0]      i_pe_busy,
`ifdef ISSUER_PERF_CNT_EN
   output logic                 o_busy,
   output logic [31:0]          o_issue_cnt,
   output logic [31:0]          o_stall_cnt
`else
   output logic                 o_busy
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARB, S_ISSUE, S_DRAIN} state_t;

   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_BARRIER = 4'hF;

   state_t                state_q, state_d;
   logic                  read_q, read_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic [N_PE-1:0]       pe_valid_q, pe_valid_d;
   logic [PE_IDX_W-1:0]   rr_q, rr_d;
   logic [PE_IDX_W-1:0]   sel_q, sel_d;
   logic                  busy_q;
   logic                  arb_hit;
   logic [PE_IDX_W-1:0]   arb_sel;
   logic                  xfer;
   int                    idx;

   function automatic logic [PE_IDX_W-1:0] next_ptr(input logic [PE_IDX_W-1:0] p);
      if (p == PE_IDX_W'(N_PE - 1)) return '0;
      return p + PE_IDX_W'(1);
   endfunction

   // First ready PE at or after rr_q, wrapping; only indices below N_PE are formed.
   always_comb begin
      arb_hit = 1'b0;
      arb_sel = rr_q;
      idx     = 0;
      for (int i = 0; i < N_PE; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= N_PE) idx = idx - N_PE;
         if (!arb_hit && i_pe_ready[PE_IDX_W'(idx)]) begin
            arb_hit = 1'b1;
            arb_sel = PE_IDX_W'(idx);
         end
      end
   end

   assign xfer = (state_q == S_ISSUE) && i_pe_ready[sel_q];

   always_comb begin
      state_d    = state_q;
      read_d     = 1'b0;
      cmd_d      = cmd_q;
      pe_valid_d = pe_valid_q;
      rr_d       = rr_q;
      sel_d      = sel_q;
      case (state_q)
         S_IDLE: begin
            if (!i_fifo_empty) begin
               read_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // The pop strobe is visible during the first LOAD cycle; the word arrives one cycle later.
            if (!read_q) begin
               cmd_d = i_cmd;
               case (i_cmd[CMD_WIDTH-1 -: 4])
                  OP_NOP:     state_d = S_IDLE;
                  OP_BARRIER: state_d = S_DRAIN;
                  default:    state_d = S_ARB;
               endcase
            end
         end
         S_ARB: begin
            if (arb_hit) begin
               pe_valid_d          = '0;
               pe_valid_d[arb_sel] = 1'b1;
               sel_d               = arb_sel;
               state_d             = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (xfer) begin
               pe_valid_d = '0;
               rr_d       = next_ptr(sel_q);
               state_d    = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (i_pe_busy == '0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q    <= S_IDLE;
         read_q     <= 1'b0;
         cmd_q      <= '0;
         pe_valid_q <= '0;
         rr_q       <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         read_q     <= read_d;
         cmd_q      <= cmd_d;
         pe_valid_q <= pe_valid_d;
         rr_q       <= rr_d;
         sel_q      <= sel_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign o_read     = read_q;
   assign o_cmd      = cmd_q;
   assign o_pe_valid = pe_valid_q;
   assign o_busy     = busy_q;

`ifdef ISSUER_PERF_CNT_EN
   logic [31:0] issue_cnt_q, stall_cnt_q;
   logic        stall;

   assign stall = ((state_q == S_ARB) && !arb_hit) || ((state_q == S_ISSUE) && !xfer);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (xfer)  issue_cnt_q <= issue_cnt_q + 32'd1;
         if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign o_issue_cnt = issue_cnt_q;
   assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_issuer.sv
// Bench for cmd_issuer: directed scenarios plus randomized traffic, checked against a
// queue-based model of the FIFO, the issue order and the round-robin rule.
module tb_cmd_issuer;

   localparam int CW = 248;
   localparam int NP = 4;

   logic           i_clk = 1'b0;
   logic           i_rstn = 1'b0;
   logic           i_fifo_empty = 1'b1;
   logic [CW-1:0]  i_cmd = '0;
   logic           o_read;
   logic [CW-1:0]  o_cmd;
   logic [NP-1:0]  o_pe_valid;
   logic [NP-1:0]  i_pe_ready = '0;
   logic [NP-1:0]  i_pe_busy = '0;
   logic           o_busy;

   cmd_issuer #(.CMD_WIDTH(CW), .N_PE(NP)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_fifo_empty(i_fifo_empty), .i_cmd(i_cmd),
      .o_read(o_read), .o_cmd(o_cmd), .o_pe_valid(o_pe_valid), .i_pe_ready(i_pe_ready),
      .i_pe_busy(i_pe_busy), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model state
   logic [CW-1:0] fifo_q[$];
   logic [CW-1:0] exp_issue[$];
   logic [NP-1:0] obs_tgt[$];
   logic [CW-1:0] drive_word = '0;
   bit            drive_pend = 0;
   int            cyc = 0, pop_cyc = -100, nop_cyc = -100, bar_cyc = 0, model_rr = 0, n_xfer = 0;
   bit            pend_issue = 0, bar_pend = 0, bar_exit = 0;
   bit            prev_xfer = 0, prev_read = 0, prev_empty = 1;
   logic [NP-1:0] prev_valid = '0, prev_ready = '0;
   logic [CW-1:0] prev_cmd = '0;

   function automatic logic [NP-1:0] rr_pick(input int rr, input logic [NP-1:0] rdy);
      for (int i = 0; i < NP; i++) begin
         int k = (rr + i) % NP;
         if (rdy[k]) return NP'(1) << k;
      end
      return '0;
   endfunction

   function automatic logic [CW-1:0] rand_word(input logic [3:0] op);
      logic [CW-1:0] w = '0;
      for (int i = 0; i < 8; i++) w = {w[CW-33:0], 32'($urandom)};
      w[CW-1 -: 4] = op;
      return w;
   endfunction

   task automatic push(input logic [CW-1:0] w);
      fifo_q.push_back(w);
      if (w[CW-1 -: 4] != 4'h0 && w[CW-1 -: 4] != 4'hF) exp_issue.push_back(w);
   endtask

   // Queue read data appears the cycle after the pop strobe.
   always @(posedge i_clk) begin
      #2;
      if (drive_pend) begin
         i_cmd      = drive_word;
         drive_pend = 0;
      end
      i_fifo_empty = (fifo_q.size() == 0);
   end

   always @(negedge i_clk) begin
      bit            cur_xfer;
      logic [3:0]    op;
      logic [CW-1:0] exp_cmd;
      cyc++;
      if (!i_rstn) begin
         model_rr = 0; exp_issue.delete(); pend_issue = 0; bar_pend = 0; bar_exit = 0;
         nop_cyc = -100; pop_cyc = -100; prev_valid = '0; prev_xfer = 0; prev_read = 0;
         prev_empty = 1; prev_ready = i_pe_ready; prev_cmd = '0;
      end else begin
         cur_xfer = |(o_pe_valid & i_pe_ready);
         if (o_read) begin
            chk("read_when_empty", 256'(prev_empty), 256'(0));
            chk("read_pulse_width", 256'(prev_read), 256'(0));
            chk("pop_has_entry", 256'(fifo_q.size() != 0), 256'(1));
            if (fifo_q.size() != 0) begin
               drive_word = fifo_q.pop_front();
               drive_pend = 1;
               pop_cyc    = cyc;
               op         = drive_word[CW-1 -: 4];
               if (op == 4'h0) nop_cyc = cyc + 2;
               else if (op == 4'hF) begin bar_pend = 1; bar_cyc = cyc; end
               else pend_issue = 1;
            end
         end
         if (cyc == pop_cyc + 1) chk("load_busy", 256'(o_busy), 256'(1));
         if (cyc == nop_cyc) chk("nop_back_idle", 256'(o_busy), 256'(0));
         if (bar_exit) begin
            chk("barrier_exit_idle", 256'(o_busy), 256'(0));
            bar_exit = 0;
         end
         if (bar_pend) begin
            chk("barrier_busy", 256'(o_busy), 256'(1));
            chk("barrier_no_valid", 256'(o_pe_valid), 256'(0));
            if (cyc >= bar_cyc + 2 && i_pe_busy == '0) begin bar_pend = 0; bar_exit = 1; end
         end
         if (pend_issue && cyc >= pop_cyc + 3 && prev_valid == '0)
            chk("arb_grant", 256'(o_pe_valid != '0), 256'(prev_ready != '0));
         if (o_pe_valid != '0 && prev_valid == '0) begin
            exp_cmd = (exp_issue.size() != 0) ? exp_issue[0] : '0;
            chk("issue_queued", 256'(exp_issue.size() != 0), 256'(1));
            chk("rr_target", 256'(o_pe_valid), 256'(rr_pick(model_rr, prev_ready)));
            chk("issue_cmd", 256'(o_cmd), 256'(exp_cmd));
            obs_tgt.push_back(o_pe_valid);
         end
         if (prev_valid != '0 && !prev_xfer) begin
            chk("valid_held", 256'(o_pe_valid), 256'(prev_valid));
            chk("cmd_held", 256'(o_cmd), 256'(prev_cmd));
         end
         if (prev_xfer) chk("valid_cleared", 256'(o_pe_valid), 256'(0));
         if (cur_xfer) begin
            for (int k = 0; k < NP; k++) if (o_pe_valid[k]) model_rr = (k + 1) % NP;
            if (exp_issue.size() != 0) void'(exp_issue.pop_front());
            pend_issue = 0;
            n_xfer++;
         end
         prev_xfer = cur_xfer; prev_read = o_read; prev_empty = i_fifo_empty;
         prev_valid = o_pe_valid; prev_ready = i_pe_ready; prev_cmd = o_cmd;
      end
   end

   task automatic wait_read();
      int n = 0;
      do begin @(negedge i_clk); n++; end while (!o_read && n < 60);
      if (!o_read) chk("read_timeout", 256'(o_read), 256'(1));
   endtask

   task automatic wait_done();
      int n = 0;
      while (n < 400 && (fifo_q.size() != 0 || exp_issue.size() != 0 || o_busy || drive_pend)) begin
         @(negedge i_clk);
         n++;
      end
      chk("settle_pending", 256'(exp_issue.size()), 256'(0));
      chk("settle_busy", 256'(o_busy), 256'(0));
   endtask

   task automatic chk_obs(input int i, input logic [NP-1:0] exp);
      logic [NP-1:0] got;
      got = (obs_tgt.size() > i) ? obs_tgt[i] : '0;
      chk("target_seq", 256'(got), 256'(exp));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [CW-1:0] w;
      repeat (3) @(posedge i_clk);
      #1 i_rstn = 1'b1;

      // Idle with empty FIFO
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("idle_read", 256'(o_read), 256'(0));
         chk("idle_valid", 256'(o_pe_valid), 256'(0));
         chk("idle_busy", 256'(o_busy), 256'(0));
      end

      // Single command, A5 payload, all PEs ready
      @(posedge i_clk); #1;
      i_pe_ready = 4'b1111;
      w = '0;
      for (int i = 0; i < CW / 8; i++) w[i*8 +: 8] = 8'hA5;
      w[CW-1 -: 4] = 4'h1;
      push(w);
      wait_read();
      repeat (3) @(negedge i_clk);
      chk("first_valid", 256'(o_pe_valid), 256'(4'b0001));
      chk("first_cmd", 256'(o_cmd), 256'(w));
      wait_done();

      // Four back-to-back, rotation continues from PE1 and wraps
      obs_tgt.delete();
      @(posedge i_clk); #1;
      for (int i = 0; i < 4; i++) push(rand_word(4'(i + 2)));
      wait_done();
      chk_obs(0, 4'b0010); chk_obs(1, 4'b0100); chk_obs(2, 4'b1000); chk_obs(3, 4'b0001);

      // No PE ready, then PE2 only for one cycle; grant held until accepted
      obs_tgt.delete();
      @(posedge i_clk); #1;
      i_pe_ready = 4'b0000;
      push(rand_word(4'h7));
      wait_read();
      for (int i = 0; i < 7; i++) begin
         @(negedge i_clk);
         chk("stall_no_valid", 256'(o_pe_valid), 256'(0));
      end
      @(posedge i_clk); #1 i_pe_ready = 4'b0100;
      @(posedge i_clk); #1 i_pe_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("pe2_valid_held", 256'(o_pe_valid), 256'(4'b0100));
      end
      @(posedge i_clk); #1 i_pe_ready = 4'b0100;
      @(posedge i_clk); #1 i_pe_ready = 4'b1111;
      push(rand_word(4'h3));
      wait_done();
      chk_obs(0, 4'b0100); chk_obs(1, 4'b1000);

      // NOP then BARRIER while PE1 busy
      obs_tgt.delete();
      @(posedge i_clk); #1;
      i_pe_busy = 4'b0010;
      push(rand_word(4'h0));
      push(rand_word(4'hF));
      wait_read();
      wait_read();
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         chk("drain_busy", 256'(o_busy), 256'(1));
         chk("drain_no_valid", 256'(o_pe_valid), 256'(0));
      end
      @(posedge i_clk); #1 i_pe_busy = 4'b0000;
      @(negedge i_clk);
      chk("drain_last_cycle", 256'(o_busy), 256'(1));
      @(negedge i_clk);
      chk("drain_released", 256'(o_busy), 256'(0));
      @(posedge i_clk); #1;
      push(rand_word(4'h5));
      wait_done();
      chk_obs(0, 4'b0001);
      chk("barrier_no_issue", 256'(obs_tgt.size()), 256'(1));

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(posedge i_clk); #1;
         i_pe_ready = NP'($urandom);
         i_pe_busy  = ($urandom_range(0, 2) == 0) ? '0 : NP'($urandom);
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) begin
            case ($urandom_range(0, 9))
               0:       push(rand_word(4'h0));
               1:       push(rand_word(4'hF));
               default: push(rand_word(4'($urandom_range(1, 14))));
            endcase
         end
      end
      @(posedge i_clk); #1;
      i_pe_ready = 4'b1111;
      i_pe_busy  = 4'b0000;
      wait_done();

      // Asynchronous reset while a grant is outstanding
      obs_tgt.delete();
      @(posedge i_clk); #1;
      i_pe_ready = 4'b0000;
      push(rand_word(4'h9));
      wait_read();
      repeat (3) @(negedge i_clk);
      @(posedge i_clk); #1 i_pe_ready = 4'b1000;
      @(posedge i_clk); #1 i_pe_ready = 4'b0000;
      @(negedge i_clk);
      chk("pre_reset_valid", 256'(o_pe_valid), 256'(4'b1000));
      #2 i_rstn = 1'b0;
      #1;
      chk("rst_valid", 256'(o_pe_valid), 256'(0));
      chk("rst_busy", 256'(o_busy), 256'(0));
      chk("rst_cmd", 256'(o_cmd), 256'(0));
      chk("rst_read", 256'(o_read), 256'(0));
      repeat (2) @(posedge i_clk);
      #1 i_rstn = 1'b1;
      obs_tgt.delete();
      i_pe_ready = 4'b1111;
      push(rand_word(4'h4));
      wait_done();
      chk_obs(0, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
